// File: rtl/mips_pkg.sv
// Shared MIPS definitions: MDU funct codes and the multiply/divide unit state encoding.
package mips_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO: WIDTH step cycles plus one sign-fix cycle.
// Stalls any presented op while busy; MT*/MF* complete without entering the FSM.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_valid,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  import mips_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_t         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b, r_srca, r_hi, r_lo;
  logic               r_neg_q, r_neg_r, r_div0, r_is_div, r_done;

  logic               w_accept, w_is_mul, w_is_div, w_signed, w_sa, w_sb, w_sub;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_q, w_r;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH+1:0]   w_add_a, w_add_b, w_sum;

  assign busy    = (r_state != IDLE);
  assign stall   = op_valid && busy;
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rd_data = (funct == FUNCT_W'(FN_MFHI)) ? r_hi : r_lo;

  assign w_accept = op_valid && !busy;
  assign w_is_mul = (funct == FUNCT_W'(FN_MULT)) || (funct == FUNCT_W'(FN_MULTU));
  assign w_is_div = (funct == FUNCT_W'(FN_DIV))  || (funct == FUNCT_W'(FN_DIVU));
  assign w_signed = (funct == FUNCT_W'(FN_MULT)) || (funct == FUNCT_W'(FN_DIV));
  assign w_sa     = w_signed && srca[WIDTH-1];
  assign w_sb     = w_signed && srcb[WIDTH-1];
  assign w_mag_a  = w_sa ? -srca : srca;
  assign w_mag_b  = w_sb ? -srcb : srcb;

  // One adder serves both loops: multiply adds the multiplicand when the low
  // multiplier bit is set; divide trial-subtracts from the shifted remainder.
  assign w_sub = (r_state == DIV);
  always_comb begin
    w_add_a = {2'b00, r_acc[2*WIDTH-1:WIDTH]};
    w_add_b = {2'b00, r_b} & {(WIDTH+2){r_acc[0]}};
    if (w_sub) begin
      w_add_a = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]};
      w_add_b = ~{2'b00, r_b};
    end
  end
  assign w_sum = w_add_a + w_add_b + (WIDTH+2)'(w_sub);

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_q    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = MUL;
        else if (w_accept && w_is_div) w_state_nxt = DIV;
      end
      MUL, DIV: if (r_cnt == LAST) w_state_nxt = FIX;
      FIX:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_srca   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          if (funct == FUNCT_W'(FN_MTHI)) r_hi <= srca;
          if (funct == FUNCT_W'(FN_MTLO)) r_lo <= srca;
          if (w_is_mul || w_is_div) begin
            r_acc    <= {{WIDTH{1'b0}}, (w_is_mul ? w_mag_b : w_mag_a)};
            r_b      <= w_is_mul ? w_mag_a : w_mag_b;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_div0   <= (srcb == '0);
            r_is_div <= w_is_div;
            r_srca   <= srca;
            r_cnt    <= '0;
          end
        end
        MUL: begin
          r_acc <= {w_sum[WIDTH:0], r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
        end
        DIV: begin
          if (!w_sum[WIDTH+1]) r_acc <= {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
          else                 r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_cnt  <= '0;
          r_done <= 1'b1;
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_div0) begin
            // Divide-by-zero: all-ones quotient, dividend passed through as remainder.
            r_lo <= '1;
            r_hi <= r_srca;
          end else begin
            r_lo <= w_q;
            r_hi <= w_r;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
